// File: rtl/adder_pipe_pkg.sv
// adder_pipe_pkg: shared constants and types for the pipelined adder/subtractor.
//   DEF_WIDTH / DEF_STAGES : default operand width and pipeline depth
//   chunk_width()          : bits resolved per pipeline stage
//   stage_entry_t          : layout of one pipeline entry at the default width
//                            (adder_pipe declares the same layout at its own WIDTH)
package adder_pipe_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

  typedef struct packed {
    logic                 vld;    // entry holds a live operation
    logic                 carry;  // carry out of the chunk resolved in this stage
    logic [DEF_WIDTH-1:0] psum;   // sum bits resolved so far (lower chunks)
    logic [DEF_WIDTH-1:0] pa;     // operand A, upper chunks still pending
    logic [DEF_WIDTH-1:0] pbx;    // operand B after subtract inversion
  } stage_entry_t;

endpackage

// File: rtl/adder_chunk.sv
// adder_chunk: combinational CW-bit ripple-carry adder built from per-bit full adders.
//   a, b  : CW-bit chunk operands
//   cin   : carry into bit 0
//   sum   : CW-bit chunk sum
//   cout  : carry out of the chunk MSB
//   cmsb  : carry into the chunk MSB (only with ADDER_PIPE_OVF_EN defined)
module adder_chunk #(
  parameter int CW = 8
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic          cmsb
`endif
);

  logic [CW:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CW; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CW];

`ifdef ADDER_PIPE_OVF_EN
  assign cmsb = c[CW-1];
`endif

endmodule

// File: rtl/adder_pipe.sv
// adder_pipe: pipelined ripple-carry adder/subtractor with valid/ready on both sides.
// Operands are split into STAGES chunks of WIDTH/STAGES bits; stage k ripples chunk k
// using the carry registered by stage k-1, so the result appears STAGES cycles after
// acceptance and one operation per cycle is sustained.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid / in_ready : operand handshake (in_ready low while rst or stalled)
//   a, b, cin, sub      : operands; sub=1 computes a - b - cin (cin is borrow-in)
//   out_valid/out_ready : result handshake
//   sum, cout           : result and MSB carry (sub: cout=1 means no borrow)
//   ovf                 : signed overflow, present only with ADDER_PIPE_OVF_EN defined
// A stall (out_valid && !out_ready) freezes every stage; bubbles move as vld=0 entries.
module adder_pipe
  import adder_pipe_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef ADDER_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);

  if ((STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_param_check
    $error("adder_pipe: WIDTH (%0d) must be a multiple of STAGES (%0d)", WIDTH, STAGES);
  end

  typedef struct packed {
    logic             vld;
    logic             carry;
    logic [WIDTH-1:0] psum;
    logic [WIDTH-1:0] pa;
    logic [WIDTH-1:0] pbx;
  } stage_t;

  stage_t           pipe_p [STAGES];
  logic             en;
  logic [WIDTH-1:0] bx;
  logic             c0;

  // Subtraction is a + ~b + ~cin, so a borrow-in of 1 becomes a carry-in of 0.
  assign bx = b ^ {WIDTH{sub}};
  assign c0 = cin ^ sub;

  assign en       = !pipe_p[STAGES-1].vld || out_ready;
  assign in_ready = en && !rst;

`ifdef ADDER_PIPE_OVF_EN
  logic cmsb_w [STAGES];
  logic ovf_p;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // src.carry is the carry into chunk k; the registered carry is the carry out of it.
    stage_t           src;
    logic [CHUNK-1:0] cs;
    logic             co;
    logic [WIDTH-1:0] nsum;

    if (k == 0) begin : g_src
      always_comb begin
        src       = '0;
        src.vld   = in_valid;
        src.carry = c0;
        src.pa    = a;
        src.pbx   = bx;
      end
    end else begin : g_src
      assign src = pipe_p[k-1];
    end

    adder_chunk #(
      .CW(CHUNK)
    ) u_chunk (
      .a   (src.pa[k*CHUNK +: CHUNK]),
      .b   (src.pbx[k*CHUNK +: CHUNK]),
      .cin (src.carry),
      .sum (cs),
      .cout(co)
`ifdef ADDER_PIPE_OVF_EN
      ,
      .cmsb(cmsb_w[k])
`endif
    );

    always_comb begin
      nsum                     = src.psum;
      nsum[k*CHUNK +: CHUNK]   = cs;
    end

    // ---- stage k register boundary ----
    always_ff @(posedge clk) begin
      if (rst) begin
        pipe_p[k].vld <= 1'b0;
      end else if (en) begin
        pipe_p[k].vld <= src.vld;
      end
      // Only the last stage drives the outputs, so only its data is cleared.
      if (rst && (k == STAGES-1)) begin
        pipe_p[k].carry <= 1'b0;
        pipe_p[k].psum  <= '0;
      end else if (en) begin
        pipe_p[k].carry <= co;
        pipe_p[k].psum  <= nsum;
      end
      if (en) begin
        pipe_p[k].pa  <= src.pa;
        pipe_p[k].pbx <= src.pbx;
      end
    end

`ifdef ADDER_PIPE_OVF_EN
    if (k == STAGES-1) begin : g_ovf
      // Signed overflow: carry into the MSB differs from carry out of it.
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_p <= 1'b0;
        end else if (en) begin
          ovf_p <= cmsb_w[k] ^ co;
        end
      end
    end
`endif
  end

  assign out_valid = pipe_p[STAGES-1].vld;
  assign sum       = pipe_p[STAGES-1].psum;
  assign cout      = pipe_p[STAGES-1].carry;

`ifdef ADDER_PIPE_OVF_EN
  assign ovf = ovf_p;
`endif

endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed self-checking bench for adder_pipe at WIDTH=8 with
// STAGES=4 (main instance), STAGES=1 and STAGES=8 (streamed alongside).
module tb_adder_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       iv_x;
  logic       or_x;
  logic [7:0] a, b;
  logic       cin, sub;
  logic       out_ready;

  logic       in_ready4, out_valid4, cout4;
  logic [7:0] sum4;
  logic       in_ready1, out_valid1, cout1;
  logic [7:0] sum1;
  logic       in_ready8, out_valid8, cout8;
  logic [7:0] sum8;
`ifdef ADDER_PIPE_OVF_EN
  logic       ovf4, ovf1, ovf8;
`endif

  int tests = 0;
  int fails = 0;

  // {a, b, cin, sub, expected sum, expected cout}
  localparam logic [26:0] VEC [16] = '{
    {8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0},
    {8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0},
    {8'hFF, 8'hFF, 1'b0, 1'b0, 8'hFE, 1'b1},
    {8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1},
    {8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1},
    {8'h55, 8'hAA, 1'b0, 1'b0, 8'hFF, 1'b0},
    {8'h55, 8'hAA, 1'b1, 1'b0, 8'h00, 1'b1},
    {8'h3C, 8'hC3, 1'b0, 1'b0, 8'hFF, 1'b0},
    {8'h20, 8'h10, 1'b0, 1'b1, 8'h10, 1'b1},
    {8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0},
    {8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1},
    {8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0},
    {8'h0F, 8'hF1, 1'b0, 1'b0, 8'h00, 1'b1},
    {8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 1'b0},
    {8'h9A, 8'h3B, 1'b1, 1'b1, 8'h5E, 1'b1},
    {8'h01, 8'hFF, 1'b0, 1'b1, 8'h02, 1'b0}
  };

  always #5 clk = ~clk;

  adder_pipe #(.WIDTH(8), .STAGES(4)) u4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid4), .out_ready(out_ready), .sum(sum4), .cout(cout4)
`ifdef ADDER_PIPE_OVF_EN
    , .ovf(ovf4)
`endif
  );

  adder_pipe #(.WIDTH(8), .STAGES(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(iv_x), .in_ready(in_ready1),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid1), .out_ready(or_x), .sum(sum1), .cout(cout1)
`ifdef ADDER_PIPE_OVF_EN
    , .ovf(ovf1)
`endif
  );

  adder_pipe #(.WIDTH(8), .STAGES(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(iv_x), .in_ready(in_ready8),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid8), .out_ready(or_x), .sum(sum8), .cout(cout8)
`ifdef ADDER_PIPE_OVF_EN
    , .ovf(ovf8)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int i);
    logic [26:0] v;
    v   = VEC[i];
    a   = v[26:19];
    b   = v[18:11];
    cin = v[10];
    sub = v[9];
  endtask

  // Issues one operation on u4 and waits for its result; lat counts edges from accept.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input logic tcin,
                       input logic tsub, output logic [7:0] rs, output logic rc,
                       output logic ro, output int lat);
    a = ta; b = tb; cin = tcin; sub = tsub;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid4 && lat < 20) begin
      step();
      lat++;
    end
    rs = sum4;
    rc = cout4;
`ifdef ADDER_PIPE_OVF_EN
    ro = ovf4;
`else
    ro = 1'b0;
`endif
    step();
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b1; in_valid = 1'b1; iv_x = 1'b0; or_x = 1'b1; out_ready = 1'b1;
    a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0;
    step();
    step();
    tests++;
    if (in_ready4 !== 1'b0) begin fails++; $display("FAIL rst_in_ready_low: got %b want 0", in_ready4); end
    rst = 1'b0; in_valid = 1'b0;
    #1;
    tests++;
    if (in_ready4 !== 1'b1) begin fails++; $display("FAIL rst_in_ready_high: got %b want 1", in_ready4); end
    tests++;
    if (out_valid4 !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid4); end
    tests++;
    if (sum4 !== 8'h00) begin fails++; $display("FAIL rst_sum: got %h want 00", sum4); end
    tests++;
    if (cout4 !== 1'b0) begin fails++; $display("FAIL rst_cout: got %b want 0", cout4); end
`ifdef ADDER_PIPE_OVF_EN
    tests++;
    if (ovf4 !== 1'b0) begin fails++; $display("FAIL rst_ovf: got %b want 0", ovf4); end
`endif
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (out_valid4) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL rst_dominates_valid: got output=%b want 0", seen); end
  endtask

  task automatic test_basic();
    logic [7:0] s; logic c, o; int lat;
    do_op(8'h0F, 8'h01, 1'b0, 1'b0, s, c, o, lat);
    tests++;
    if (lat !== 4) begin fails++; $display("FAIL basic_latency: got %0d want 4", lat); end
    tests++;
    if (s !== 8'h10) begin fails++; $display("FAIL basic_sum: got %h want 10", s); end
    tests++;
    if (c !== 1'b0) begin fails++; $display("FAIL basic_cout: got %b want 0", c); end
  endtask

  task automatic test_overflow();
    logic [7:0] s; logic c, o; int lat;
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, s, c, o, lat);
    tests++;
    if (s !== 8'h00) begin fails++; $display("FAIL wrap_sum: got %h want 00", s); end
    tests++;
    if (c !== 1'b1) begin fails++; $display("FAIL wrap_cout: got %b want 1", c); end
`ifdef ADDER_PIPE_OVF_EN
    tests++;
    if (o !== 1'b0) begin fails++; $display("FAIL wrap_ovf: got %b want 0", o); end
`endif
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, s, c, o, lat);
    tests++;
    if (s !== 8'h80) begin fails++; $display("FAIL sovf_sum: got %h want 80", s); end
    tests++;
    if (c !== 1'b0) begin fails++; $display("FAIL sovf_cout: got %b want 0", c); end
`ifdef ADDER_PIPE_OVF_EN
    tests++;
    if (o !== 1'b1) begin fails++; $display("FAIL sovf_ovf: got %b want 1", o); end
`endif
  endtask

  task automatic test_sub();
    logic [7:0] s; logic c, o; int lat;
    do_op(8'h05, 8'h07, 1'b0, 1'b1, s, c, o, lat);
    tests++;
    if (s !== 8'hFE) begin fails++; $display("FAIL sub_borrow_sum: got %h want fe", s); end
    tests++;
    if (c !== 1'b0) begin fails++; $display("FAIL sub_borrow_cout: got %b want 0", c); end
    do_op(8'h07, 8'h05, 1'b1, 1'b1, s, c, o, lat);
    tests++;
    if (s !== 8'h01) begin fails++; $display("FAIL sub_bin_sum: got %h want 01", s); end
    tests++;
    if (c !== 1'b1) begin fails++; $display("FAIL sub_bin_cout: got %b want 1", c); end
    do_op(8'h80, 8'h01, 1'b0, 1'b1, s, c, o, lat);
    tests++;
    if (s !== 8'h7F) begin fails++; $display("FAIL sub_min_sum: got %h want 7f", s); end
    tests++;
    if (c !== 1'b1) begin fails++; $display("FAIL sub_min_cout: got %b want 1", c); end
`ifdef ADDER_PIPE_OVF_EN
    tests++;
    if (o !== 1'b1) begin fails++; $display("FAIL sub_min_ovf: got %b want 1", o); end
`endif
  endtask

  task automatic test_back_to_back();
    int o4 = 0, o1 = 0, o8 = 0;
    int first4 = -1, first1 = -1, first8 = -1, last4 = -1;
    logic [26:0] v;
    out_ready = 1'b1; or_x = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc < 16) begin
        set_vec(cyc); in_valid = 1'b1; iv_x = 1'b1;
      end else begin
        in_valid = 1'b0; iv_x = 1'b0;
      end
      #1;
      if (out_valid4) begin
        if (o4 < 16) begin
          v = VEC[o4];
          tests++;
          if ({sum4, cout4} !== {v[8:1], v[0]}) begin
            fails++; $display("FAIL b2b_s4[%0d]: got %h/%b want %h/%b", o4, sum4, cout4, v[8:1], v[0]);
          end
        end
        if (first4 < 0) first4 = cyc;
        last4 = cyc;
        o4++;
      end
      if (out_valid1) begin
        if (o1 < 16) begin
          v = VEC[o1];
          tests++;
          if ({sum1, cout1} !== {v[8:1], v[0]}) begin
            fails++; $display("FAIL b2b_s1[%0d]: got %h/%b want %h/%b", o1, sum1, cout1, v[8:1], v[0]);
          end
        end
        if (first1 < 0) first1 = cyc;
        o1++;
      end
      if (out_valid8) begin
        if (o8 < 16) begin
          v = VEC[o8];
          tests++;
          if ({sum8, cout8} !== {v[8:1], v[0]}) begin
            fails++; $display("FAIL b2b_s8[%0d]: got %h/%b want %h/%b", o8, sum8, cout8, v[8:1], v[0]);
          end
        end
        if (first8 < 0) first8 = cyc;
        o8++;
      end
      step();
    end
    tests++;
    if (o4 !== 16 || o1 !== 16 || o8 !== 16) begin
      fails++; $display("FAIL b2b_count: got %0d/%0d/%0d want 16/16/16", o4, o1, o8);
    end
    tests++;
    if (first4 !== 4 || first1 !== 1 || first8 !== 8) begin
      fails++; $display("FAIL b2b_latency: got %0d/%0d/%0d want 4/1/8", first4, first1, first8);
    end
    tests++;
    if (last4 - first4 !== 15) begin
      fails++; $display("FAIL b2b_rate: got span %0d want 15", last4 - first4);
    end
  endtask

  task automatic test_stall();
    int i = 0, o = 0, stalled = 0;
    bit acc;
    logic [26:0] v;
    iv_x = 1'b0;
    for (int cyc = 0; cyc < 80 && o < 16; cyc++) begin
      out_ready = !(cyc >= 6 && cyc < 12);
      if (i < 16) begin
        set_vec(i); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid4 && o < 16) begin
        v = VEC[o];
        tests++;
        if ({sum4, cout4} !== {v[8:1], v[0]}) begin
          fails++; $display("FAIL stall_data[%0d]: got %h/%b want %h/%b", o, sum4, cout4, v[8:1], v[0]);
        end
        if (!out_ready) begin
          stalled++;
          tests++;
          if (in_ready4 !== 1'b0) begin fails++; $display("FAIL stall_in_ready: got %b want 0", in_ready4); end
        end else begin
          o++;
        end
      end
      acc = in_valid && in_ready4;
      step();
      if (acc) i++;
    end
    tests++;
    if (o !== 16 || i !== 16) begin fails++; $display("FAIL stall_count: got out %0d in %0d want 16/16", o, i); end
    tests++;
    if (stalled !== 6) begin fails++; $display("FAIL stall_cycles: got %0d want 6", stalled); end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    step();
    tests++;
    if (out_valid4 !== 1'b0) begin fails++; $display("FAIL stall_no_dup: got %b want 0", out_valid4); end
  endtask

  task automatic test_reset_flight();
    bit seen = 1'b0;
    logic [7:0] s; logic c, o; int lat;
    out_ready = 1'b1; or_x = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_vec(k + 2); in_valid = 1'b1; iv_x = 1'b1;
      #1;
      step();
    end
    in_valid = 1'b0; iv_x = 1'b0; rst = 1'b1;
    #1;
    step();
    rst = 1'b0;
    #1;
    tests++;
    if (out_valid4 !== 1'b0 || out_valid1 !== 1'b0 || out_valid8 !== 1'b0) begin
      fails++; $display("FAIL flush_valid: got %b%b%b want 000", out_valid4, out_valid1, out_valid8);
    end
    tests++;
    if (sum4 !== 8'h00 || cout4 !== 1'b0) begin
      fails++; $display("FAIL flush_data: got %h/%b want 00/0", sum4, cout4);
    end
    for (int k = 0; k < 12; k++) begin
      step();
      if (out_valid4 || out_valid1 || out_valid8) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin fails++; $display("FAIL flush_stale: got output=%b want 0", seen); end
    do_op(8'h0F, 8'h01, 1'b0, 1'b0, s, c, o, lat);
    tests++;
    if (s !== 8'h10 || lat !== 4) begin
      fails++; $display("FAIL flush_recover: got %h lat %0d want 10 lat 4", s, lat);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_sub();
    test_back_to_back();
    test_stall();
    test_reset_flight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
